sdram_port_arbiter: RTL

//  Shares the single SDRAM controller command port between the ADC capture writer and the host read path.

---
 rtl/sdram_port_arbiter_if.sv | 61 ++++++
 rtl/sdram_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdram_port_arbiter_if                                     |
// | Purpose  : Bundles the ADC writer, host reader and SDRAM controller  |
// |            command-port signals seen by sdram_port_arbiter.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 10
);
   // ADC capture writer
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [LEN_W-1:0]  wr_len;
   logic [DATA_W-1:0] wr_data;
   logic              wr_pop;
   logic              wr_done;
   // host read path
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [LEN_W-1:0]  rd_len;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_done;
   logic              rd_err;
   // SDRAM controller command port
   logic              sdram_cmd;
   logic              sdram_we;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_wdata;
   logic              sdram_stall;
   logic [DATA_W-1:0] sdram_rdata;
   logic              sdram_rvalid;
   // status
   logic              busy;

   // arbiter side: drives the SDRAM command and the requester responses
   modport master (
      input  wr_req, wr_addr, wr_len, wr_data,
      input  rd_req, rd_addr, rd_len,
      input  sdram_stall, sdram_rdata, sdram_rvalid,
      output wr_pop, wr_done,
      output rd_data, rd_valid, rd_done, rd_err,
      output sdram_cmd, sdram_we, sdram_addr, sdram_wdata,
      output busy
   );

   // requester / controller side
   modport slave (
      output wr_req, wr_addr, wr_len, wr_data,
      output rd_req, rd_addr, rd_len,
      output sdram_stall, sdram_rdata, sdram_rvalid,
      input  wr_pop, wr_done,
      input  rd_data, rd_valid, rd_done, rd_err,
      input  sdram_cmd, sdram_we, sdram_addr, sdram_wdata,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sdram_port_arbiter                                        |
// | Purpose  : Shares one SDRAM controller command port between the ADC  |
// |            capture writer and the host read path; one burst at a     |
// |            time, write-favoured with a bounded write streak and a    |
// |            read-return timeout.                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sdram_port_arbiter #(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 10,
   parameter int WR_STREAK  = 4,
   parameter int RD_TIMEOUT = 1023
) (
   input  wire logic            clk,
   input  wire logic            reset,   // synchronous, active-low
   sdram_port_arbiter_if.master bus
);

   localparam int c_STREAK_W = $clog2(WR_STREAK + 1);
   localparam int c_TMR_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(WR_STREAK);
   // timer value on the last quiet cycle before the abort
   localparam logic [c_TMR_W-1:0]    c_TMR_LAST   = c_TMR_W'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_CMD  = 3'd1,
      S_WR_DATA = 3'd2,
      S_RD_CMD  = 3'd3,
      S_RD_DATA = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_cnt;
   logic [c_TMR_W-1:0]  r_timer;
   logic [c_STREAK_W-1:0] r_streak;
   logic                r_is_wr;
   logic                r_err;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;

   logic                w_grant_rd;
   logic                w_grant_wr;
   logic [LEN_W-1:0]    w_len_m1;
   logic                w_rd_last;
   logic                w_timeout;

   assign w_len_m1   = r_len - LEN_W'(1);
   // a waiting read only overtakes a pending write once the streak is used up
   assign w_grant_rd = bus.rd_req && (!bus.wr_req || (r_streak == c_STREAK_MAX));
   assign w_grant_wr = bus.wr_req && !w_grant_rd;
   assign w_rd_last  = bus.sdram_rvalid && (r_cnt == w_len_m1);
   assign w_timeout  = !bus.sdram_rvalid && (r_timer == c_TMR_LAST);

   assign bus.sdram_addr = r_addr;
   assign bus.rd_data    = r_rd_data;
   assign bus.rd_valid   = r_rd_valid;

   // state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state decode and state-derived outputs
   always_comb begin
      w_next          = r_state;
      bus.sdram_cmd   = 1'b0;
      bus.sdram_we    = 1'b0;
      bus.sdram_wdata = '0;
      bus.wr_pop      = 1'b0;
      bus.wr_done     = 1'b0;
      bus.rd_done     = 1'b0;
      bus.rd_err      = 1'b0;
      bus.busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            // a zero-length burst skips the controller and only reports done
            if (w_grant_wr)      w_next = (bus.wr_len == '0) ? S_DONE : S_WR_CMD;
            else if (w_grant_rd) w_next = (bus.rd_len == '0) ? S_DONE : S_RD_CMD;
         end
         S_WR_CMD: begin
            bus.sdram_cmd = 1'b1;
            bus.sdram_we  = 1'b1;
            if (!bus.sdram_stall) w_next = S_WR_DATA;
         end
         S_WR_DATA: begin
            // stall is no longer honoured once the burst is under way
            bus.sdram_cmd   = 1'b1;
            bus.sdram_we    = 1'b1;
            bus.sdram_wdata = bus.wr_data;
            bus.wr_pop      = 1'b1;
            if (r_cnt == w_len_m1) w_next = S_DONE;
         end
         S_RD_CMD: begin
            bus.sdram_cmd = 1'b1;
            if (!bus.sdram_stall) w_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (w_rd_last || w_timeout) w_next = S_DONE;
         end
         S_DONE: begin
            bus.wr_done = r_is_wr;
            bus.rd_done = !r_is_wr;
            bus.rd_err  = !r_is_wr && r_err;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // burst context, word counter, streak, timeout timer and read return path
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr     <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_timer    <= '0;
         r_streak   <= '0;
         r_is_wr    <= 1'b0;
         r_err      <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_err <= 1'b0;
               if (w_grant_wr) begin
                  r_addr  <= bus.wr_addr;
                  r_len   <= bus.wr_len;
                  r_is_wr <= 1'b1;
                  if (r_streak != c_STREAK_MAX) r_streak <= r_streak + c_STREAK_W'(1);
               end else if (w_grant_rd) begin
                  r_addr   <= bus.rd_addr;
                  r_len    <= bus.rd_len;
                  r_is_wr  <= 1'b0;
                  r_streak <= '0;
               end
            end
            S_WR_CMD: r_cnt <= '0;
            S_WR_DATA: r_cnt <= r_cnt + LEN_W'(1);
            S_RD_CMD: begin
               r_cnt   <= '0;
               r_timer <= '0;
            end
            S_RD_DATA: begin
               // returns only land here; rvalid in any other state is dropped
               if (bus.sdram_rvalid) begin
                  r_rd_data  <= bus.sdram_rdata;
                  r_rd_valid <= 1'b1;
                  r_cnt      <= r_cnt + LEN_W'(1);
                  r_timer    <= '0;
               end else begin
                  r_timer <= r_timer + c_TMR_W'(1);
                  if (w_timeout) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
